// File: rtl/encoder_pkg.sv
// Shared types and sizes for the serial 16-to-4 encoder.
package encoder_pkg;

  localparam int WIDTH  = 16;
  localparam int CODE_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/priority_enc16.sv
// Combinational lowest-set-bit finder with empty and single-bit flags.
module priority_enc16
  import encoder_pkg::*;
(
  input  logic [WIDTH-1:0]  i_vec,
  output logic [CODE_W-1:0] o_idx,
  output logic              o_none,
  output logic              o_single
);

  // Descending scan so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = CODE_W'(i);
    end
  end

  assign o_none   = (i_vec == '0);
  assign o_single = !o_none && ((i_vec & (i_vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/encoder16to4_serial.sv
// Serial 16-to-4 encoder: captures a request vector and streams the index
// of each set bit, lowest first, over a valid/ready output.
module encoder16to4_serial
  import encoder_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_enable,
  input  logic [WIDTH-1:0]  i_enc_in,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic [CODE_W-1:0] o_enc_out,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_last,
  output logic              o_done
);

  state_t              r_state, w_state_nxt;
  logic [WIDTH-1:0]    r_pending, w_pending_nxt;
  logic [CODE_W-1:0]   r_enc_out, w_enc_nxt;
  logic                r_out_last, w_last_nxt;
  logic                r_done, w_done_nxt;

  logic [CODE_W-1:0]   w_in_idx, w_rest_idx;
  logic                w_in_none, w_in_single;
  logic                w_rest_none, w_rest_single;
  logic [WIDTH-1:0]    w_rest;
  logic                w_in_xfer, w_out_xfer;

  // Remaining work once the code currently on the output is accepted.
  assign w_rest = r_pending & ~(WIDTH'(1) << r_enc_out);

  priority_enc16 u_in_enc (
    .i_vec    (i_enc_in),
    .o_idx    (w_in_idx),
    .o_none   (w_in_none),
    .o_single (w_in_single)
  );

  priority_enc16 u_rest_enc (
    .i_vec    (w_rest),
    .o_idx    (w_rest_idx),
    .o_none   (w_rest_none),
    .o_single (w_rest_single)
  );

  assign o_in_ready  = (r_state == ST_IDLE) && !i_enable && i_reset_n;
  assign o_out_valid = (r_state == ST_SCAN) && !i_enable && i_reset_n;
  assign o_enc_out   = r_enc_out;
  assign o_out_last  = r_out_last;
  assign o_done      = r_done;

  assign w_in_xfer  = i_in_valid  && o_in_ready;
  assign w_out_xfer = o_out_valid && i_out_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_enc_nxt     = r_enc_out;
    w_last_nxt    = r_out_last;
    w_done_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_in_xfer) begin
          if (w_in_none) begin
            w_done_nxt = 1'b1;
          end else begin
            w_pending_nxt = i_enc_in;
            w_enc_nxt     = w_in_idx;
            w_last_nxt    = w_in_single;
            w_state_nxt   = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        if (w_out_xfer) begin
          w_pending_nxt = w_rest;
          if (w_rest_none) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_enc_nxt  = w_rest_idx;
            w_last_nxt = w_rest_single;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= ST_IDLE;
      r_pending  <= '0;
      r_enc_out  <= '0;
      r_out_last <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_enc_out  <= w_enc_nxt;
      r_out_last <= w_last_nxt;
      r_done     <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_encoder16to4_serial.sv
// Directed bench for encoder16to4_serial with a queue-based reference model.
module tb_encoder16to4_serial;

  logic        clk = 1'b0;
  logic        reset_n, enable, in_valid, out_ready;
  logic [15:0] enc_in;
  logic        in_ready, out_valid, out_last, done;
  logic [3:0]  enc_out;

  int n_vec = 0;
  int n_err = 0;

  encoder16to4_serial dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_enable    (enable),
    .i_enc_in    (enc_in),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .o_enc_out   (enc_out),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_last  (out_last),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the indices still owed to the consumer, in order.
  int q[$];
  bit exp_done = 1'b0;
  bit started  = 1'b0;
  int rec_code[$];
  int rec_last[$];

  always @(posedge clk) begin
    started <= 1'b1;
    if (out_valid === 1'b1 && out_ready && reset_n) begin
      rec_code.push_back(int'(enc_out));
      rec_last.push_back(int'(out_last));
    end
    exp_done = 1'b0;
    if (!reset_n) begin
      q.delete();
    end else if (!enable) begin
      if (q.size() == 0 && in_valid) begin
        for (int i = 0; i < 16; i++) if (enc_in[i]) q.push_back(i);
        if (enc_in == 16'h0) exp_done = 1'b1;
      end else if (q.size() > 0 && out_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) exp_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      bit ev;
      ev = (q.size() > 0) && !enable && reset_n;
      chk("out_valid", int'(out_valid), int'(ev));
      chk("in_ready", int'(in_ready), int'((q.size() == 0) && !enable && reset_n));
      chk("done", int'(done), int'(exp_done));
      if (ev) begin
        chk("enc_out", int'(enc_out), q[0]);
        chk("out_last", int'(out_last), int'(q.size() == 1));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_rec(input string name, input int codes[], input int lasts[]);
    chk({name, "_count"}, rec_code.size(), codes.size());
    for (int i = 0; i < codes.size() && i < rec_code.size(); i++) begin
      chk({name, "_code"}, rec_code[i], codes[i]);
      chk({name, "_last"}, rec_last[i], lasts[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ffc[];
    int ffl[];
    reset_n = 1'b0; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b0; enc_in = '0;
    cyc(3);
    chk("rst_enc_out", int'(enc_out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", int'(in_ready), 1);
    cyc(1);

    // 8421, streaming
    rec_code.delete(); rec_last.delete();
    enc_in = 16'h8421; in_valid = 1'b1; out_ready = 1'b1;
    cyc(1);
    in_valid = 1'b0;
    chk("8421_first", int'(enc_out), 0);
    cyc(4);
    chk("8421_done", int'(done), 1);
    chk("8421_in_ready", int'(in_ready), 1);
    chk_rec("8421", '{0, 5, 10, 15}, '{0, 0, 0, 1});
    cyc(1);

    // FFFF with toggling out_ready
    rec_code.delete(); rec_last.delete();
    enc_in = 16'hFFFF; in_valid = 1'b1; out_ready = 1'b0;
    cyc(1);
    in_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      out_ready = i[0];
      cyc(1);
    end
    out_ready = 1'b0;
    chk("ffff_done", int'(done), 1);
    ffc = new[16]; ffl = new[16];
    for (int i = 0; i < 16; i++) begin ffc[i] = i; ffl[i] = (i == 15); end
    chk_rec("ffff", ffc, ffl);
    cyc(1);

    // zero vector then 0002 back to back
    enc_in = 16'h0000; in_valid = 1'b1;
    cyc(1);
    chk("zero_done", int'(done), 1);
    chk("zero_in_ready", int'(in_ready), 1);
    chk("zero_no_valid", int'(out_valid), 0);
    enc_in = 16'h0002;
    cyc(1);
    in_valid = 1'b0;
    chk("0002_valid", int'(out_valid), 1);
    chk("0002_code", int'(enc_out), 1);
    chk("0002_last", int'(out_last), 1);
    out_ready = 1'b1;
    cyc(1);
    chk("0002_done", int'(done), 1);

    // 0300 with a disable window after the first code
    enc_in = 16'h0300; in_valid = 1'b1;
    cyc(1);
    in_valid = 1'b0;
    chk("0300_first", int'(enc_out), 8);
    cyc(1);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("dis_valid", int'(out_valid), 0);
      cyc(1);
    end
    enable = 1'b0;
    #1;
    chk("0300_valid", int'(out_valid), 1);
    chk("0300_code", int'(enc_out), 9);
    chk("0300_last", int'(out_last), 1);
    cyc(1);
    chk("0300_done", int'(done), 1);

    // F000 interrupted by reset
    enc_in = 16'hF000; in_valid = 1'b1;
    cyc(1);
    in_valid = 1'b0;
    cyc(2);
    chk("f000_third", int'(enc_out), 14);
    reset_n = 1'b0;
    cyc(1);
    chk("f000_rst_valid", int'(out_valid), 0);
    chk("f000_rst_code", int'(enc_out), 0);
    chk("f000_rst_done", int'(done), 0);
    reset_n = 1'b1;
    #1;
    chk("f000_in_ready", int'(in_ready), 1);
    enc_in = 16'h0001; in_valid = 1'b1;
    cyc(1);
    in_valid = 1'b0;
    chk("0001_code", int'(enc_out), 0);
    chk("0001_last", int'(out_last), 1);
    cyc(1);
    chk("0001_done", int'(done), 1);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/encoder16to4_serial.md
# encoder16to4_serial

Sequential 16-to-4 encoder, the inverse of the team's 4-to-16 decoder. Captures a 16-bit request vector through a valid/ready handshake and emits the 4-bit index of every set bit, lowest index first, one code per accepted output transfer. It sits between status or request-flag logic and any consumer that wants binary indices. The active-low `enable` convention matches the decoder's, so the two blocks can share a control line.

## Interface
- `WIDTH`, 16: input vector width (fixed at 16 for this block).
- `CODE_W`, 4: output code width, log2(WIDTH).
- `clk`  input  1  rising-edge clock.
- `reset_n`  input  1  synchronous active-low reset.
- `enable`  input  1  active-low block enable; 1 = disabled.
- `enc_in`  input  16  request vector; sampled on input transfer.
- `in_valid`  input  1  producer presents `enc_in`.
- `in_ready`  output  1  block can accept a vector.
- `enc_out`  output  4  index of the current set bit.
- `out_valid`  output  1  `enc_out` is valid.
- `out_ready`  input  1  consumer accepts `enc_out`.
- `out_last`  output  1  current code is the final one of the vector.
- `done`  output  1  one-cycle pulse when a vector is fully drained.

## Operation
- Reset is synchronous: `reset_n` is sampled only at the rising edge of `clk`; there is no asynchronous path.
- Internal state:
  - `pending[15:0]`: set bits not yet emitted.
  - FSM with states IDLE and SCAN.
- Input transfer occurs when `in_valid & in_ready` at an edge. `in_ready` = (state == IDLE) & ~`enable` & `reset_n`.
- IDLE, input transfer:
  - If `enc_in` != 0: `pending` <= `enc_in`; `enc_out` <= index of the lowest set bit; `out_last` <= (popcount == 1); go to SCAN.
  - If `enc_in` == 0: stay in IDLE; `done` pulses the next cycle; no code is emitted.
- SCAN:
  - `out_valid` = 1 (only while `enable` = 0).
  - Output transfer when `out_valid & out_ready` at an edge: clear that bit in `pending`, then load `enc_out` and `out_last` from the new lowest set bit.
  - If the accepted code had `out_last` = 1: go to IDLE; `done` pulses for one cycle.
- Priority is strict ascending index. Bit 0 is always emitted first; bit 15 is always emitted last.
- Disabled (`enable` = 1):
  - FSM, `pending`, `enc_out` and `out_last` are frozen.
  - `out_valid` = 0, `in_ready` = 0, and `out_ready` is ignored.
  - Clearing `enable` resumes exactly where the block stopped.
- `enc_out` and `out_last` hold their last value when `out_valid` = 0; the consumer must ignore them in that case.

## Timing
- Reset values: `enc_out` = 0, `out_valid` = 0, `out_last` = 0, `done` = 0, `in_ready` = 0 during reset, `pending` = 0, state = IDLE.
- `in_ready` rises in the first cycle after `reset_n` is high, provided `enable` = 0.
- Latency: input transfer at edge k gives `out_valid` = 1 with the first code in cycle k+1.
- Throughput: one code per cycle while `out_ready` is held high. A vector with N set bits drains in N cycles after capture.
- `done` is asserted in the cycle after the final output transfer. `in_ready` is high in that same cycle, so a new vector can be captured at the end of it.
  - Minimum period between captures is N+1 cycles.
  - For a zero vector, the minimum period between captures is 1 cycle (`done` at k+1, `in_ready` stays high).
- `out_valid`, `enc_out` and `out_last` must not change while `out_valid` = 1 and `out_ready` = 0 (stall stability).
- Reset asserted mid-SCAN: the remaining `pending` bits are discarded, no `done` pulse is generated, and all outputs return to their reset values at that edge.
- `enable` rising in the same cycle as `out_ready` = 1: no transfer occurs.

## Structure
- Package `encoder_pkg` holds:
  - state encoding constants `ST_IDLE` and `ST_SCAN`;
  - `WIDTH` = 16 and `CODE_W` = 4.
- Sub-module `priority_enc16`: combinational lowest-set-bit finder.
  - Inputs: 16-bit vector.
  - Outputs: 4-bit index, a `none` flag, and a `single` flag (exactly one bit set).
  - Instantiated twice: once on `enc_in` and once on `pending` with the emitted bit cleared.
- Top level contains the FSM, the `pending` register and the output registers only.

## Test plan
- Reset, then release with `enable` = 0 -> all outputs 0 during reset; `in_ready` = 1 in the next cycle.
- `enc_in` = 16'h8421, `out_ready` held 1 -> codes 0, 5, 10, 15 on consecutive cycles; `out_last` only with 15; `done` one cycle later.
- `enc_in` = 16'hFFFF with `out_ready` toggling -> 16 codes 0..15 in order; `enc_out` stable on every stall cycle.
- `enc_in` = 16'h0000 -> `out_valid` never asserts; `done` pulses at k+1; a second vector 16'h0002 is accepted right after -> code 1 with `out_last` = 1.
- `enc_in` = 16'h0300, first code accepted, then `enable` = 1 for 5 cycles -> `out_valid` = 0 while disabled; after re-enable, code 9 with `out_last` = 1.
- `enc_in` = 16'hF000, `reset_n` low after two codes -> no `done`; `in_ready` returns to 1 after release; the next vector 16'h0001 yields code 0.
